// File: rtl/jt900h_dmasch_if.sv
// Bus between the micro-DMA scheduler and its surroundings: trigger/config
// inputs, sequencer handshake and per-channel status.
interface jt900h_dmasch_if #(
    parameter int VW = 8
);
    logic          vec_stb;
    logic [VW-1:0] vec;
    logic          cfg_we;
    logic [1:0]    cfg_ch;
    logic [VW-1:0] cfg_vec;
    logic          dma_req;
    logic [1:0]    dmach;
    logic          dma_ack;
    logic          xfer_end;
    logic          dma_done;
    logic          busy;
    logic [3:0]    pend;
    logic [3:0]    end_irq;

    modport master (
        output vec_stb, vec, cfg_we, cfg_ch, cfg_vec, dma_ack, xfer_end, dma_done,
        input  dma_req, dmach, busy, pend, end_irq
    );

    modport slave (
        input  vec_stb, vec, cfg_we, cfg_ch, cfg_vec, dma_ack, xfer_end, dma_done,
        output dma_req, dmach, busy, pend, end_irq
    );
endinterface

// File: rtl/jt900h_dmasch.sv
// Micro-DMA channel scheduler: start vectors, pending triggers, arbitration and
// end-of-count interrupts. Define JT900H_DMA_RR_EN for round-robin arbitration.
module jt900h_dmasch #(
    parameter int VW  = 8,
    parameter int GAP = 1
) (
    input  logic              rst,
    input  logic              clk,
    input  logic              cen,
    jt900h_dmasch_if.slave    bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;
    localparam logic [3:0] GAP_LD  = 4'(GAP);

    logic [VW-1:0] svec_q [4];
    logic [VW-1:0] svec_d [4];
    logic [3:0]    pend_q, pend_d;
    logic [3:0]    irq_q, irq_d;
    logic [1:0]    st_q, st_d;
    logic [1:0]    ch_q, ch_d;
    logic          req_q, req_d;
    logic          busy_q, busy_d;
    logic [3:0]    gap_q, gap_d;
`ifdef JT900H_DMA_RR_EN
    logic [1:0]    last_q, last_d;
    logic [1:0]    rr_idx;
`endif

    logic [3:0]    hit;
    logic [3:0]    cfg_sel;
    logic [3:0]    avail;
    logic [1:0]    pick;
    logic          pick_vld;
    logic          active;

    always_comb begin
        hit = '0;
        for (int unsigned n = 0; n < 4; n++) begin
            hit[n] = bus.vec_stb && (svec_q[n] != '0) && (svec_q[n] == bus.vec);
        end
        cfg_sel = bus.cfg_we ? (4'b0001 << bus.cfg_ch) : '0;
        // a channel being reconfigured this cycle must not be granted
        avail   = pend_q & ~cfg_sel;
        active  = (st_q == ST_REQ) || (st_q == ST_XFER);
    end

    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
`ifdef JT900H_DMA_RR_EN
        rr_idx   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            rr_idx = last_q + 2'(i + 1);
            if (!pick_vld && avail[rr_idx]) begin
                pick     = rr_idx;
                pick_vld = 1'b1;
            end
        end
`else
        for (int unsigned i = 0; i < 4; i++) begin
            if (!pick_vld && avail[i]) begin
                pick     = 2'(i);
                pick_vld = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        svec_d = svec_q;
        pend_d = pend_q | hit;
        st_d   = st_q;
        ch_d   = ch_q;
        req_d  = req_q;
        busy_d = busy_q;
        irq_d  = '0;
        gap_d  = gap_q;
`ifdef JT900H_DMA_RR_EN
        last_d = last_q;
`endif
        case (st_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    ch_d  = pick;
                    req_d = 1'b1;
                    st_d  = ST_REQ;
`ifdef JT900H_DMA_RR_EN
                    last_d = pick;
`endif
                end
            end
            ST_REQ: begin
                if (bus.dma_ack) begin
                    req_d        = 1'b0;
                    busy_d       = 1'b1;
                    pend_d[ch_q] = hit[ch_q];
                    st_d         = ST_XFER;
                end
            end
            ST_XFER: begin
                if (bus.dma_done) begin
                    svec_d[ch_q] = '0;
                    irq_d[ch_q]  = 1'b1;
                    busy_d       = 1'b0;
                    gap_d        = GAP_LD;
                    st_d         = ST_GAP;
                end else if (bus.xfer_end) begin
                    busy_d = 1'b0;
                    gap_d  = GAP_LD;
                    st_d   = ST_GAP;
                end
            end
            default: begin
                if (gap_q == '0) begin
                    st_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
        endcase
        // config write overrides any trigger on the same channel, except the one in service
        if (bus.cfg_we) begin
            svec_d[bus.cfg_ch] = bus.cfg_vec;
            if (!(active && (bus.cfg_ch == ch_q))) begin
                pend_d[bus.cfg_ch] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned n = 0; n < 4; n++) begin
                svec_q[n] <= '0;
            end
            pend_q <= '0;
            irq_q  <= '0;
            st_q   <= ST_IDLE;
            ch_q   <= '0;
            req_q  <= 1'b0;
            busy_q <= 1'b0;
            gap_q  <= '0;
`ifdef JT900H_DMA_RR_EN
            last_q <= 2'd3;
`endif
        end else if (cen) begin
            svec_q <= svec_d;
            pend_q <= pend_d;
            irq_q  <= irq_d;
            st_q   <= st_d;
            ch_q   <= ch_d;
            req_q  <= req_d;
            busy_q <= busy_d;
            gap_q  <= gap_d;
`ifdef JT900H_DMA_RR_EN
            last_q <= last_d;
`endif
        end
    end

    assign bus.dma_req = req_q;
    assign bus.dmach   = ch_q;
    assign bus.busy    = busy_q;
    assign bus.pend    = pend_q;
    assign bus.end_irq = irq_q;
endmodule

// File: tb/tb_jt900h_dmasch.sv
// Directed table-driven bench for jt900h_dmasch (default fixed-priority build, GAP=1).
module tb_jt900h_dmasch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    jt900h_dmasch_if #(.VW(8)) bus ();

    jt900h_dmasch #(.VW(8), .GAP(1)) dut (
        .rst (rst),
        .clk (clk),
        .cen (cen),
        .bus (bus)
    );

    typedef struct {
        logic       cen;
        logic       stb;
        logic [7:0] vec;
        logic       we;
        logic [1:0] ch;
        logic [7:0] cv;
        logic       ack;
        logic       xe;
        logic       dd;
        logic       req;
        logic [1:0] dmach;
        logic       busy;
        logic [3:0] pend;
        logic [3:0] irq;
    } vec_t;

    function automatic vec_t mk(logic stb, logic [7:0] vv, logic we, logic [1:0] ch,
                                logic [7:0] cv, logic ack, logic xe, logic dd,
                                logic req, logic [1:0] dm, logic busy,
                                logic [3:0] pend, logic [3:0] irq);
        vec_t v;
        v.cen = 1'b1; v.stb = stb; v.vec = vv; v.we = we; v.ch = ch; v.cv = cv;
        v.ack = ack; v.xe = xe; v.dd = dd;
        v.req = req; v.dmach = dm; v.busy = busy; v.pend = pend; v.irq = irq;
        return v;
    endfunction

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        cen = 1'b1;
        bus.vec_stb = 1'b0; bus.vec = '0; bus.cfg_we = 1'b0; bus.cfg_ch = '0;
        bus.cfg_vec = '0; bus.dma_ack = 1'b0; bus.xfer_end = 1'b0; bus.dma_done = 1'b0;
    endtask

    task automatic check_out(string nm, logic req, logic [1:0] dm, logic busy,
                             logic [3:0] pend, logic [3:0] irq);
        chk({nm, ".req"},   8'(bus.dma_req), 8'(req));
        chk({nm, ".dmach"}, 8'(bus.dmach),   8'(dm));
        chk({nm, ".busy"},  8'(bus.busy),    8'(busy));
        chk({nm, ".pend"},  8'(bus.pend),    8'(pend));
        chk({nm, ".irq"},   8'(bus.end_irq), 8'(irq));
    endtask

    task automatic apply(vec_t v, string nm);
        cen = v.cen;
        bus.vec_stb = v.stb; bus.vec = v.vec; bus.cfg_we = v.we; bus.cfg_ch = v.ch;
        bus.cfg_vec = v.cv; bus.dma_ack = v.ack; bus.xfer_end = v.xe; bus.dma_done = v.dd;
        @(posedge clk);
        #1;
        check_out(nm, v.req, v.dmach, v.busy, v.pend, v.irq);
        drive_idle();
    endtask

    task automatic wait_req(string nm, int unsigned max_cyc);
        bit seen = 1'b0;
        drive_idle();
        for (int unsigned k = 0; k < max_cyc && !seen; k++) begin
            @(posedge clk);
            #1;
            seen = bus.dma_req;
        end
        chk({nm, ".req_seen"}, 8'(seen), 8'd1);
    endtask

    vec_t tbl[$];

    initial begin
        vec_t v;
        drive_idle();
        // Main table: (stb vec we ch cv ack xe dd) -> (req dmach busy pend irq)
        tbl.push_back(mk(0, 8'h00, 1, 0, 8'h0A, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 1, 1, 8'h10, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 1, 2, 8'h10, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 1, 3, 8'h33, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(1, 8'h0A, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 4'b0001, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 4'b0001, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 4'b0001, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(1, 8'h10, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 4'b0110, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 1, 0, 4'b0110, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 1, 1, 4'b0100, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 4'b0100, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 4'b0100, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 4'b0100, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 2, 0, 4'b0100, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 2, 1, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 2, 0, 4'b0000, 4'b0100));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 2, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 2, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(1, 8'h10, 0, 0, 8'h00, 0, 0, 0, 0, 2, 0, 4'b0010, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 1, 0, 4'b0010, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 1, 1, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 0, 1, 0, 4'b0000, 4'b0010));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(1, 8'h10, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1, 1, 1, 0, 1, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(1, 8'h33, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 4'b1000, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 3, 0, 4'b1000, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 3, 1, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 3, 0, 4'b0000, 4'b1000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 3, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 3, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(1, 8'h33, 0, 0, 8'h00, 0, 0, 0, 0, 3, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 3, 0, 4'b0000, 4'b0000));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_out("reset", 0, 0, 0, 4'b0000, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // ch2 waiting in REQ is not re-arbitrated when ch0 becomes pending; retrigger in XFER
        apply(mk(0, 8'h00, 1, 2, 8'h22, 0, 0, 0, 0, 3, 0, 4'b0000, 4'b0000), "hold.cfg");
        apply(mk(1, 8'h22, 0, 0, 8'h00, 0, 0, 0, 0, 3, 0, 4'b0100, 4'b0000), "hold.trg2");
        apply(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 2, 0, 4'b0100, 4'b0000), "hold.req2");
        apply(mk(1, 8'h0A, 0, 0, 8'h00, 0, 0, 0, 1, 2, 0, 4'b0101, 4'b0000), "hold.trg0");
        apply(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 2, 0, 4'b0101, 4'b0000), "hold.wait");
        apply(mk(0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 2, 1, 4'b0001, 4'b0000), "hold.ack");
        apply(mk(1, 8'h22, 0, 0, 8'h00, 0, 0, 0, 0, 2, 1, 4'b0101, 4'b0000), "hold.retrg");
        apply(mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 2, 0, 4'b0101, 4'b0000), "hold.xend");
        apply(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 2, 0, 4'b0101, 4'b0000), "hold.gap");
        wait_req("hold.next0", 8);
        chk("hold.next0.dmach", 8'(bus.dmach), 8'd0);
        apply(mk(0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 4'b0100, 4'b0000), "hold.ack0");
        apply(mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 4'b0100, 4'b0000), "hold.xend0");
        wait_req("hold.next2", 8);
        chk("hold.next2.dmach", 8'(bus.dmach), 8'd2);
        apply(mk(0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 2, 1, 4'b0000, 4'b0000), "hold.ack2");
        apply(mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 2, 0, 4'b0000, 4'b0000), "hold.xend2");
        apply(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 2, 0, 4'b0000, 4'b0000), "hold.gap2");
        apply(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 2, 0, 4'b0000, 4'b0000), "hold.idle2");

        // Config write disabling ch1 in the same cycle as its trigger
        apply(mk(0, 8'h00, 1, 1, 8'h44, 0, 0, 0, 0, 2, 0, 4'b0000, 4'b0000), "coll.cfg");
        apply(mk(1, 8'h44, 1, 1, 8'h00, 0, 0, 0, 0, 2, 0, 4'b0000, 4'b0000), "coll.both");
        apply(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 2, 0, 4'b0000, 4'b0000), "coll.noreq");
        apply(mk(1, 8'h44, 0, 0, 8'h00, 0, 0, 0, 0, 2, 0, 4'b0000, 4'b0000), "coll.dis");

        // End-of-count pulse held frozen while cen=0
        apply(mk(1, 8'h0A, 0, 0, 8'h00, 0, 0, 0, 0, 2, 0, 4'b0001, 4'b0000), "frz.trg");
        wait_req("frz.req", 4);
        chk("frz.req.dmach", 8'(bus.dmach), 8'd0);
        apply(mk(0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 4'b0000, 4'b0000), "frz.ack");
        apply(mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 4'b0000, 4'b0001), "frz.done");
        for (int k = 0; k < 5; k++) begin
            v = mk(1, 8'h0A, 1, 2, 8'h0A, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0001);
            v.cen = 1'b0;
            apply(v, $sformatf("frz.hold%0d", k));
        end
        apply(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000), "frz.release");
        apply(mk(1, 8'h0A, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000), "frz.svec0");

        // Asynchronous reset in the middle of a transfer
        apply(mk(0, 8'h00, 1, 3, 8'h55, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000), "rst.cfg");
        apply(mk(1, 8'h55, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 4'b1000, 4'b0000), "rst.trg");
        wait_req("rst.req", 4);
        apply(mk(0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 3, 1, 4'b0000, 4'b0000), "rst.ack");
        #2;
        rst = 1'b1;
        #1;
        check_out("rst.async", 0, 0, 0, 4'b0000, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        apply(mk(1, 8'h55, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000), "rst.svec");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
